// File: rtl/i2c_apb_regfile_v2_if.sv
// APB bus bundle between the interconnect and the I2C master register file.
interface i2c_apb_regfile_v2_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) ();
    logic              psel_i;
    logic              penable_i;
    logic              pwrite_i;
    logic [ADDR_W-1:0] paddr_i;
    logic [DATA_W-1:0] pwdata_i;
    logic [DATA_W-1:0] prdata_o;
    logic              pready_o;
    logic              pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/i2c_apb_regfile_v2.sv
// APB register file for the I2C master: configuration registers, read wait
// states, error response, latched maskable interrupts and FIFO push/pop strobes.
module i2c_apb_regfile_v2 #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned RD_WAIT   = 0,
    parameter int unsigned IRQ_N     = 5,
    parameter logic [7:0]  PRESC_RST = 8'h04,
    parameter logic [7:0]  CMD_RST   = 8'h04,
    parameter int unsigned EN_BIT    = 6
) (
    input  logic                 pclk_i,
    input  logic                 preset_n_i,
    i2c_apb_regfile_v2_if.slave  apb,
    input  logic [DATA_W-1:0]    status_i,
    input  logic                 stop_done_i,
    input  logic [IRQ_N-1:0]     irq_src_i,
    input  logic                 tx_full_i,
    input  logic                 rx_empty_i,
    input  logic [DATA_W-1:0]    rx_data_i,
    output logic [DATA_W-1:0]    prescaler_o,
    output logic [DATA_W-1:0]    cmd_o,
    output logic [DATA_W-1:0]    address_rw_o,
    output logic [DATA_W-1:0]    transmit_o,
    output logic                 tx_push_o,
    output logic                 rx_pop_o,
    output logic                 irq_o
);
    localparam int unsigned CNT_W = 2;

    localparam logic [2:0] A_PRESC = 3'd0;
    localparam logic [2:0] A_CMD   = 3'd1;
    localparam logic [2:0] A_TX    = 3'd2;
    localparam logic [2:0] A_RX    = 3'd3;
    localparam logic [2:0] A_ADDR  = 3'd4;
    localparam logic [2:0] A_STAT  = 3'd5;
    localparam logic [2:0] A_IEN   = 3'd6;
    localparam logic [2:0] A_IST   = 3'd7;

    logic [DATA_W-1:0] r_presc, r_cmd, r_addr_rw, r_transmit, r_prdata;
    logic [IRQ_N-1:0]  r_irq_en, r_irq_stat, r_irq_src_q;
    logic [CNT_W-1:0]  r_wait;
    logic              r_pready, r_pslverr, r_tx_push, r_rx_pop, r_irq;

    logic              w_setup, w_access, w_cmpl, w_mapped, w_err;
    logic              w_wr_ok, w_rd_ok;
    logic [2:0]        w_idx;
    logic [DATA_W-1:0] w_rd_mux, w_cmd_nxt;
    logic [IRQ_N-1:0]  w_rise, w_clr;

    assign w_setup  = apb.psel_i & ~apb.penable_i;
    assign w_access = apb.psel_i & apb.penable_i;
    assign w_cmpl   = w_access & r_pready;
    assign w_mapped = (apb.paddr_i >> 3) == '0;
    assign w_idx    = apb.paddr_i[2:0];
    // Side effects only on an error-free completion
    assign w_wr_ok  = w_cmpl &  apb.pwrite_i & ~r_pslverr;
    assign w_rd_ok  = w_cmpl & ~apb.pwrite_i & ~r_pslverr;

    // Error decode for the access being set up
    always_comb begin
        w_err = 1'b0;
        if (!w_mapped) begin
            w_err = 1'b1;
        end else if (apb.pwrite_i) begin
            if (w_idx == A_RX || w_idx == A_STAT) w_err = 1'b1;
            if (w_idx == A_TX && tx_full_i)       w_err = 1'b1;
        end else if (w_idx == A_RX && rx_empty_i) begin
            w_err = 1'b1;
        end
    end

    // Read data mux; unimplemented bits are zero
    always_comb begin
        w_rd_mux = '0;
        case (w_idx)
            A_PRESC: w_rd_mux = r_presc;
            A_CMD:   w_rd_mux = r_cmd;
            A_TX:    w_rd_mux = r_transmit;
            A_RX:    w_rd_mux = rx_data_i;
            A_ADDR:  w_rd_mux = r_addr_rw;
            A_STAT:  w_rd_mux = status_i;
            A_IEN:   w_rd_mux = DATA_W'(r_irq_en);
            A_IST:   w_rd_mux = DATA_W'(r_irq_stat);
            default: w_rd_mux = '0;
        endcase
    end

    // CMD next value: a completing write loads it, stop_done always drops enable
    always_comb begin
        w_cmd_nxt = r_cmd;
        if (w_wr_ok && w_idx == A_CMD) w_cmd_nxt = apb.pwdata_i;
        if (stop_done_i)               w_cmd_nxt[EN_BIT] = 1'b0;
    end

    assign w_rise = irq_src_i & ~r_irq_src_q;
    assign w_clr  = (w_wr_ok && w_idx == A_IST) ? apb.pwdata_i[IRQ_N-1:0] : '0;

    // APB response: read data, error flag, ready and read wait counter
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
            r_pready  <= 1'b1;
            r_wait    <= '0;
        end else if (w_setup) begin
            r_pslverr <= w_err;
            if (!apb.pwrite_i) begin
                r_prdata <= w_err ? '0 : w_rd_mux;
                if (RD_WAIT > 0) begin
                    r_pready <= 1'b0;
                    r_wait   <= CNT_W'(RD_WAIT);
                end
            end
        end else if (w_access) begin
            if (r_wait != '0) begin
                r_wait <= r_wait - CNT_W'(1);
                if (r_wait == CNT_W'(1)) r_pready <= 1'b1;
            end
        end else if (!apb.psel_i) begin
            r_wait   <= '0;
            r_pready <= 1'b1;
        end
    end

    // Configuration registers written on completion
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            r_presc    <= DATA_W'(PRESC_RST);
            r_cmd      <= DATA_W'(CMD_RST);
            r_addr_rw  <= '0;
            r_transmit <= '0;
            r_irq_en   <= '0;
        end else begin
            r_cmd <= w_cmd_nxt;
            if (w_wr_ok) begin
                case (w_idx)
                    A_PRESC: r_presc    <= apb.pwdata_i;
                    A_TX:    r_transmit <= apb.pwdata_i;
                    A_ADDR:  r_addr_rw  <= apb.pwdata_i;
                    A_IEN:   r_irq_en   <= apb.pwdata_i[IRQ_N-1:0];
                    default: ;
                endcase
            end
        end
    end

    // One-cycle FIFO strobes following each completion
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            r_tx_push <= 1'b0;
            r_rx_pop  <= 1'b0;
        end else begin
            r_tx_push <= w_wr_ok && w_idx == A_TX;
            r_rx_pop  <= w_rd_ok && w_idx == A_RX;
        end
    end

    // Interrupt status: rising edges set, W1C clears, set has priority
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            r_irq_src_q <= '0;
            r_irq_stat  <= '0;
            r_irq       <= 1'b0;
        end else begin
            r_irq_src_q <= irq_src_i;
            r_irq_stat  <= (r_irq_stat & ~w_clr) | w_rise;
            r_irq       <= |(r_irq_stat & r_irq_en);
        end
    end

    assign apb.prdata_o  = r_prdata;
    assign apb.pready_o  = r_pready;
    assign apb.pslverr_o = r_pslverr;
    assign prescaler_o   = r_presc;
    assign cmd_o         = r_cmd;
    assign address_rw_o  = r_addr_rw;
    assign transmit_o    = r_transmit;
    assign tx_push_o     = r_tx_push;
    assign rx_pop_o      = r_rx_pop;
    assign irq_o         = r_irq;
endmodule

// File: doc/i2c_apb_regfile_v2.md
Name: i2c_apb_regfile_v2

Overview:
- Parametrised APB slave register file for the I2C master. It generalises the first-generation register block: configurable data/address width, programmable read wait states, and a PSLVERR error response.
- Adds a latched, maskable interrupt controller with write-1-to-clear status, and single-cycle TX push / RX pop strobes toward the FIFOs.
- Sits between the APB interconnect and the I2C core/FIFOs; all core configuration comes from this block's registers.

Parameters:
DATA_W, 8, register and APB data width (>= 8)
ADDR_W, 8, APB address width
RD_WAIT, 0, wait states inserted on every read access (0..3)
IRQ_N, 5, number of interrupt sources (<= DATA_W)
PRESC_RST, 8'h04, PRESCALER reset value (zero-extended to DATA_W)
CMD_RST, 8'h04, CMD reset value (zero-extended to DATA_W)
EN_BIT, 6, CMD bit index of the core enable bit

Ports:
pclk_i  in  1  clock
preset_n_i  in  1  reset, asynchronous, active-low
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  1 = write
paddr_i  in  ADDR_W  APB address
pwdata_i  in  DATA_W  APB write data
prdata_o  out  DATA_W  APB read data
pready_o  out  1  APB ready
pslverr_o  out  1  APB error
status_i  in  DATA_W  core status, read-only
stop_done_i  in  1  core finished STOP (1-cycle pulse)
irq_src_i  in  IRQ_N  level interrupt sources from core/FIFOs
tx_full_i  in  1  TX FIFO full
rx_empty_i  in  1  RX FIFO empty
rx_data_i  in  DATA_W  RX FIFO head (first-word-fall-through)
prescaler_o  out  DATA_W  PRESCALER register
cmd_o  out  DATA_W  CMD register
address_rw_o  out  DATA_W  ADDR_RW register
transmit_o  out  DATA_W  last TXDATA written
tx_push_o  out  1  TX FIFO write strobe
rx_pop_o  out  1  RX FIFO read strobe
irq_o  out  1  interrupt request

Behaviour:
- Register map:
  - 0x00 PRESCALER, RW
  - 0x01 CMD, RW
  - 0x02 TXDATA, RW: a write pushes the TX FIFO; a read returns the last value written
  - 0x03 RXDATA, RO: a read pops the RX FIFO
  - 0x04 ADDR_RW, RW
  - 0x05 STATUS, RO
  - 0x06 IRQ_EN, RW, low IRQ_N bits
  - 0x07 IRQ_STAT, W1C, low IRQ_N bits
  - Unimplemented register bits read 0.
- Reset values:
  - prescaler_o=PRESC_RST; cmd_o=CMD_RST; address_rw_o=0; transmit_o=0; IRQ_EN=0; IRQ_STAT=0.
  - prdata_o=0; pready_o=1; pslverr_o=0; tx_push_o=0; rx_pop_o=0; irq_o=0; wait counter=0.
  - Asserting reset mid-transfer returns everything to these values immediately and aborts the transfer with no side effects.
- Setup phase (psel_i=1, penable_i=0), all outputs registered:
  - For a read, prdata_o loads the addressed register (RXDATA takes rx_data_i).
  - pslverr_o is loaded with the error decode.
  - If the access is a read and RD_WAIT>0: pready_o<=0 and the wait counter loads RD_WAIT.
- Access phase (psel_i=1, penable_i=1):
  - While the wait counter is nonzero it decrements; pready_o rises when it reaches 1.
  - pready_o is therefore low for exactly RD_WAIT access cycles. Writes are always zero-wait.
- Completion is the cycle with psel_i & penable_i & pready_o; all side effects happen only there:
  - Register writes take effect.
  - tx_push_o or rx_pop_o is set high in the following cycle for exactly 1 cycle.
  - W1C writes take effect.
- Error decode, evaluated in the setup phase. Any of these sets pslverr_o=1:
  - unmapped address;
  - write to 0x03 or 0x05;
  - write to TXDATA while tx_full_i=1;
  - read of RXDATA while rx_empty_i=1.
  - An errored access completes normally with no register update, no push/pop and no W1C. prdata_o=0 on an errored read.
- pslverr_o and prdata_o hold their values until the next setup phase.
- stop_done_i=1 clears cmd[EN_BIT] on the next edge. If a CMD write completes in the same cycle, the other bits take pwdata_i and EN_BIT is cleared (stop wins).
- Interrupts:
  - A rising edge on irq_src_i[k] (the previous value is registered) sets IRQ_STAT[k].
  - Writing 1 to IRQ_STAT[k] clears it. A set and a clear in the same cycle: set wins.
  - irq_o is registered: irq_o <= |(IRQ_STAT & IRQ_EN), so there is 1 cycle of latency from the status change.
- APB deassertion (psel_i=0) with the wait counter active: the counter clears and pready_o returns to 1 with no side effects.
- Back-to-back transfers (setup directly after completion) are fully supported; pulses never merge because each completion yields a separate 1-cycle pulse.

Test Plan:
- Reset released -> read 0x00 returns 0x04, 0x01 returns 0x04, 0x07 returns 0x00; pready_o=1, pslverr_o=0, irq_o=0.
- Write 0x02=0xA5 with tx_full_i=0 -> tx_push_o high exactly 1 cycle after completion, transmit_o=0xA5. Repeat with tx_full_i=1 -> pslverr_o=1, no pulse, transmit_o stays 0xA5.
- RD_WAIT=2, read 0x03 with rx_data_i=0x3C, rx_empty_i=0 -> pready_o low for 2 access cycles, prdata_o=0x3C, single rx_pop_o pulse. With rx_empty_i=1 -> pslverr_o=1, prdata_o=0, no pop.
- Write 0x01=0x55 (EN set) in the same cycle as stop_done_i=1 -> cmd_o=0x15. Later stop_done_i alone with cmd_o=0x40 -> cmd_o=0x00.
- IRQ_EN=0x02, irq_src_i[1] rises -> IRQ_STAT=0x02, irq_o=1 one cycle later. Write 0x07=0x02 -> irq_o=0. Edge coinciding with the W1C -> bit stays 1.
- Write to 0x05, write to 0x09, read of 0x0A -> pslverr_o=1 on each, no register changes, read data 0.
